ow_presence_responder: RTL and testbench

Slave-side counterpart of the 1-Wire master's presence waiter. It watches the open-drain bus for a master reset pulse (low for at least RESET_MIN_US). After the master releases the bus, it waits PRESENCE_DELAY_US and then pulls the bus low for PRESENCE_LEN_US as the presence pulse. It sits in the 1-Wire slave/device model and is used both as a bus-functional responder for exercising the master blocks and as the front end of a future slave core.

---
 rtl/ow_presence_responder.sv | 153 +++++++++++++++
 tb/tb_ow_presence_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ow_presence_responder.sv
// ow_presence_responder: 1-Wire slave front end. Watches the open-drain bus for a
// master reset pulse and answers with a presence pulse after the standard delay.
`timescale 1ns/1ps
module ow_presence_responder #(
    parameter int CLKS_PER_US       = 1,
    parameter int RESET_MIN_US      = 480,
    parameter int PRESENCE_DELAY_US = 30,
    parameter int PRESENCE_LEN_US   = 120
) (
    input  logic clk,
    input  logic rst,
    inout  wire  bus,
    input  logic en_respond,
    output logic reset_detected,
    output logic presence_active,
    output logic done_presence
);

    localparam logic [15:0] T_RST    = 16'(RESET_MIN_US * CLKS_PER_US);
    localparam logic [15:0] T_DLY_M1 = 16'(PRESENCE_DELAY_US * CLKS_PER_US - 1);
    localparam logic [15:0] T_PRS_M1 = 16'(PRESENCE_LEN_US * CLKS_PER_US - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOW_MEAS = 3'd1,
        DELAY    = 3'd2,
        PRESENCE = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        bus_meta_r;
    logic        bus_s;
    logic        drive_low_r;
    logic        reset_detected_r;
    logic        done_presence_r;

    // Counter never wraps so an arbitrarily long low still reads as a reset.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = 16'hFFFF;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Open-drain driver: only ever pulls low, straight from a flop.
    assign bus = drive_low_r ? 1'b0 : 1'bz;

    // Two-flop synchronizer for the asynchronous bus line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_meta_r <= 1'b1;
            bus_s      <= 1'b1;
        end else begin
            bus_meta_r <= bus;
            bus_s      <= bus_meta_r;
        end
    end

    // Reset-detect / presence FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            cnt_r            <= 16'd0;
            drive_low_r      <= 1'b0;
            reset_detected_r <= 1'b0;
            done_presence_r  <= 1'b0;
        end else if (!en_respond) begin
            state_r          <= IDLE;
            cnt_r            <= 16'd0;
            drive_low_r      <= 1'b0;
            reset_detected_r <= 1'b0;
            done_presence_r  <= 1'b0;
        end else begin
            reset_detected_r <= 1'b0;
            done_presence_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    drive_low_r <= 1'b0;
                    if (!bus_s) begin
                        state_r <= LOW_MEAS;
                        cnt_r   <= 16'd1;
                    end else begin
                        cnt_r   <= 16'd0;
                    end
                end
                LOW_MEAS: begin
                    drive_low_r <= 1'b0;
                    if (!bus_s) begin
                        cnt_r <= sat_inc(cnt_r);
                    end else if (cnt_r >= T_RST) begin
                        state_r          <= DELAY;
                        cnt_r            <= 16'd0;
                        reset_detected_r <= 1'b1;
                    end else begin
                        // Ordinary bit slot or glitch: not a reset.
                        state_r <= IDLE;
                        cnt_r   <= 16'd0;
                    end
                end
                DELAY: begin
                    if (!bus_s) begin
                        state_r     <= LOW_MEAS;
                        cnt_r       <= 16'd1;
                        drive_low_r <= 1'b0;
                    end else if (cnt_r == T_DLY_M1) begin
                        state_r     <= PRESENCE;
                        cnt_r       <= 16'd0;
                        drive_low_r <= 1'b1;
                    end else begin
                        cnt_r       <= sat_inc(cnt_r);
                        drive_low_r <= 1'b0;
                    end
                end
                PRESENCE: begin
                    if (cnt_r == T_PRS_M1) begin
                        state_r     <= RECOVER;
                        cnt_r       <= 16'd0;
                        drive_low_r <= 1'b0;
                    end else begin
                        cnt_r       <= sat_inc(cnt_r);
                        drive_low_r <= 1'b1;
                    end
                end
                RECOVER: begin
                    // Our own low is still in the synchronizer; wait for a real high.
                    drive_low_r <= 1'b0;
                    cnt_r       <= 16'd0;
                    if (bus_s) begin
                        state_r         <= IDLE;
                        done_presence_r <= 1'b1;
                    end else begin
                        state_r <= RECOVER;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 16'd0;
                    drive_low_r <= 1'b0;
                end
            endcase
        end
    end

    assign reset_detected  = reset_detected_r;
    assign presence_active = drive_low_r;
    assign done_presence   = done_presence_r;

endmodule

// File: tb/tb_ow_presence_responder.sv
// Directed bench for ow_presence_responder: reset-length boundaries, re-reset,
// enable drop, async reset and a scaled-clock instance.
`timescale 1ns/1ps
module tb_ow_presence_responder;

    logic clk;
    logic rst;
    logic en_respond;
    logic m_low;
    logic m_low4;
    wire  bus;
    wire  bus4;
    logic rd1, pa1, dp1;
    logic rd4, pa4, dp4;

    int checks;
    int errors;

    int rd_cnt, rd_first, low_cnt, low_first, low_last;
    int dp_cnt, dp_first, pa_bad, overlap, pa_during;

    pullup (bus);
    pullup (bus4);
    assign bus  = m_low  ? 1'b0 : 1'bz;
    assign bus4 = m_low4 ? 1'b0 : 1'bz;

    ow_presence_responder u_dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .en_respond      (en_respond),
        .reset_detected  (rd1),
        .presence_active (pa1),
        .done_presence   (dp1)
    );

    ow_presence_responder #(.CLKS_PER_US(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus4),
        .en_respond      (en_respond),
        .reset_detected  (rd4),
        .presence_active (pa4),
        .done_presence   (dp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Master holds its line low for n cycles, then releases just after an edge.
    task automatic master_reset(input int n, input bit use4);
        pa_during = 0;
        if (use4) m_low4 = 1'b1; else m_low = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if ((use4 ? pa4 : pa1) !== 1'b0) pa_during++;
        end
        m_low  = 1'b0;
        m_low4 = 1'b0;
    endtask

    // Observe ncyc cycles after a release; k counts edges since the release.
    task automatic run_window(input int ncyc, input bit use4);
        logic o_rd, o_pa, o_dp, o_bus;
        rd_cnt = 0; rd_first = -1; low_cnt = 0; low_first = -1; low_last = -1;
        dp_cnt = 0; dp_first = -1; pa_bad = 0; overlap = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            o_rd  = use4 ? rd4  : rd1;
            o_pa  = use4 ? pa4  : pa1;
            o_dp  = use4 ? dp4  : dp1;
            o_bus = use4 ? bus4 : bus;
            if (o_rd === 1'b1) begin
                if (rd_first < 0) rd_first = k;
                rd_cnt++;
            end
            if (o_dp === 1'b1) begin
                if (dp_first < 0) dp_first = k;
                dp_cnt++;
            end
            if (o_bus === 1'b0) begin
                if (low_first < 0) low_first = k;
                low_last = k;
                low_cnt++;
            end
            if (o_pa !== (o_bus === 1'b0)) pa_bad++;
            if (o_rd === 1'b1 && o_dp === 1'b1) overlap++;
        end
    endtask

    task automatic check_normal(input string tag, input int dly, input int prs);
        check({tag, "_rd_cnt"},    rd_cnt,    1);
        check({tag, "_rd_at"},     rd_first,  3);
        check({tag, "_low_cnt"},   low_cnt,   prs);
        check({tag, "_low_first"}, low_first, 3 + dly);
        check({tag, "_low_last"},  low_last,  2 + dly + prs);
        check({tag, "_dp_cnt"},    dp_cnt,    1);
        check({tag, "_dp_at"},     dp_first,  6 + dly + prs);
        check({tag, "_pa_bus"},    pa_bad,    0);
        check({tag, "_overlap"},   overlap,   0);
    endtask

    task automatic check_silent(input string tag);
        check({tag, "_rd_cnt"},  rd_cnt,  0);
        check({tag, "_low_cnt"}, low_cnt, 0);
        check({tag, "_dp_cnt"},  dp_cnt,  0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en_respond = 1'b1;
        m_low = 1'b0;
        m_low4 = 1'b0;

        repeat (3) tick();
        check("rst_rd",   rd1, 1'b0);
        check("rst_pa",   pa1, 1'b0);
        check("rst_dp",   dp1, 1'b0);
        check("rst_bus",  bus, 1'b1);
        check("rst_bus4", bus4, 1'b1);
        rst = 1'b0;
        repeat (5) tick();

        // Basic 500-cycle reset.
        master_reset(500, 1'b0);
        run_window(200, 1'b0);
        check_normal("basic", 30, 120);
        repeat (10) tick();

        // Exactly at the threshold.
        master_reset(480, 1'b0);
        run_window(200, 1'b0);
        check_normal("min480", 30, 120);
        repeat (10) tick();

        // One cycle short of the threshold.
        master_reset(479, 1'b0);
        run_window(200, 1'b0);
        check_silent("short479");
        repeat (10) tick();

        // Master re-resets 10 cycles into the delay.
        master_reset(500, 1'b0);
        run_window(13, 1'b0);
        check("rer_rd_cnt",  rd_cnt,  1);
        check("rer_low_cnt", low_cnt, 0);
        master_reset(500, 1'b0);
        check("rer_pa_during", pa_during, 0);
        run_window(200, 1'b0);
        check_normal("rereset", 30, 120);
        repeat (10) tick();

        // Enable dropped 50 cycles into the presence pulse.
        master_reset(500, 1'b0);
        repeat (83) tick();
        check("en_pre_pa", pa1, 1'b1);
        en_respond = 1'b0;
        tick();
        check("en_bus_rel", bus, 1'b1);
        check("en_pa_low",  pa1, 1'b0);
        run_window(100, 1'b0);
        check_silent("en_after");
        master_reset(500, 1'b0);
        check("en_off_pa_during", pa_during, 0);
        run_window(200, 1'b0);
        check_silent("en_off");
        en_respond = 1'b1;
        repeat (10) tick();

        // Asynchronous reset in the middle of the presence pulse.
        master_reset(500, 1'b0);
        repeat (83) tick();
        check("ar_pre_pa", pa1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_bus", bus, 1'b1);
        check("ar_pa",  pa1, 1'b0);
        check("ar_rd",  rd1, 1'b0);
        check("ar_dp",  dp1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        master_reset(500, 1'b0);
        run_window(200, 1'b0);
        check_normal("after_rst", 30, 120);
        repeat (10) tick();

        // Scaled instance: four clocks per microsecond.
        master_reset(1920, 1'b1);
        run_window(650, 1'b1);
        check_normal("clk4", 120, 480);
        check("clk4_main_idle", pa1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
